// File: rtl/router_port_reader.sv
// Drains one packet at a time from a router output-port FIFO, forwards header and
// payload over a valid/ready stream, checks the trailing parity byte and keeps stats.
module router_port_reader #(
    parameter int START_DELAY = 0,
    parameter int STALL_LIMIT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        pkt_done,
    output logic        parity_err,
    output logic        trunc_err,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, WAIT = 3'd1, HDR = 3'd2, BODY = 3'd3, PAR = 3'd4, DONE = 3'd5
    } state_t;

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    state_t          state, state_nxt;
    logic [4:0]      dly_cnt;
    logic [SW-1:0]   stall_cnt;
    logic            in_flight;
    logic [5:0]      remaining;
    logic [7:0]      par_acc;
    logic            par_err_r, trunc_r;
    logic [1:0][7:0] buf_data;
    logic [1:0]      buf_sop, buf_eop;
    logic            wr_ptr, rd_ptr;
    logic [1:0]      occ;

    logic       capture, pop, push, push_sop, push_eop, quota, reading, stall_abort;
    logic [2:0] occ_sum;
    logic [5:0] hdr_len;

    // Stream handshake: a byte transfers on every clock where rx_valid and rx_ready are
    // both high; rx_valid never depends on rx_ready and the head entry is held until taken.
    assign capture  = in_flight;
    assign hdr_len  = data_out[7:2];
    assign pop      = (occ != 2'd0) && rx_ready;
    assign occ_sum  = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
    assign reading  = (state == HDR) || (state == BODY) || (state == PAR);
    assign read_enb = quota && vld_out && (occ_sum < 3'd2);

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        quota       = 1'b0;
        push        = 1'b0;
        push_sop    = 1'b0;
        push_eop    = 1'b0;
        stall_abort = reading && !vld_out && (stall_cnt == STALL_LAST);
        case (state)
            IDLE: if (vld_out) state_nxt = (START_DELAY == 0) ? HDR : WAIT;
            WAIT: begin
                if (!vld_out)             state_nxt = IDLE;
                else if (dly_cnt <= 5'd1) state_nxt = HDR;
            end
            HDR: begin
                // The first payload read may issue in the header capture cycle so the
                // stream runs back to back.
                quota = !in_flight || (capture && (hdr_len != 6'd0));
                if (capture) begin
                    push      = 1'b1;
                    push_sop  = 1'b1;
                    push_eop  = (hdr_len == 6'd0);
                    state_nxt = (hdr_len == 6'd0) ? PAR : BODY;
                end
            end
            BODY: begin
                quota = (remaining != 6'd0);
                if (capture) begin
                    push     = 1'b1;
                    push_eop = (remaining == 6'd0);
                    if (remaining == 6'd0) state_nxt = PAR;
                end
            end
            PAR: begin
                quota = !in_flight;
                if (capture) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stall_abort) state_nxt = DONE;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dly_cnt   <= 5'd0;
            stall_cnt <= '0;
            in_flight <= 1'b0;
            remaining <= 6'd0;
            par_acc   <= 8'd0;
            par_err_r <= 1'b0;
            trunc_r   <= 1'b0;
            buf_data  <= '0;
            buf_sop   <= 2'b00;
            buf_eop   <= 2'b00;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            pkt_count <= 16'd0;
            err_count <= 8'd0;
        end else begin
            in_flight <= read_enb;
            if (state == IDLE)      dly_cnt <= 5'(START_DELAY);
            else if (state == WAIT) dly_cnt <= dly_cnt - 5'd1;
            stall_cnt <= (reading && !vld_out) ? stall_cnt + 1'b1 : '0;

            if (state == HDR && capture) begin
                par_acc   <= data_out;
                remaining <= hdr_len - 6'(read_enb);
            end
            if (state == BODY) begin
                if (read_enb) remaining <= remaining - 6'd1;
                if (capture)  par_acc   <= par_acc ^ data_out;
            end
            if (state == PAR && capture) begin
                par_err_r <= (data_out != par_acc);
                trunc_r   <= 1'b0;
            end
            if (stall_abort) begin
                par_err_r <= 1'b0;
                trunc_r   <= 1'b1;
            end
            if (state == DONE) begin
                pkt_count <= pkt_count + 16'd1;
                if ((par_err_r || trunc_r) && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end

            if (push) begin
                buf_data[wr_ptr] <= data_out;
                buf_sop[wr_ptr]  <= push_sop;
                buf_eop[wr_ptr]  <= push_eop;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    assign rx_valid   = (occ != 2'd0);
    assign rx_data    = rx_valid ? buf_data[rd_ptr] : 8'd0;
    assign rx_sop     = rx_valid && buf_sop[rd_ptr];
    assign rx_eop     = rx_valid && buf_eop[rd_ptr];
    assign pkt_done   = (state == DONE);
    assign parity_err = (state == DONE) && par_err_r;
    assign trunc_err  = (state == DONE) && trunc_r;
    assign fsm_state  = state;

endmodule

// File: doc/router_port_reader.md
Name: router_port_reader

Overview:
- Downstream consumer for one router output port.
- Monitors vld_out_x / data_out_x, drives read_enb_x and drains one packet at a time from the port FIFO.
- Header byte layout: [7:2] payload length, [1:0] destination address.
- Forwards header and payload to a local sink over a valid/ready stream, checks the trailing parity byte and keeps per-port statistics.
- Instantiated three times, one per output port, beside the router top.

Parameters:
- START_DELAY, 0: idle cycles between vld_out rising and the first read_enb; legal range 0..25, keeping well clear of the 30-cycle soft-reset window.
- STALL_LIMIT, 16: consecutive cycles with a read pending and vld_out low before a packet is declared truncated.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- vld_out  in  1  port FIFO non-empty.
- data_out  in  8  port FIFO read data; valid the cycle after read_enb is sampled high while vld_out=1.
- read_enb  out  1  FIFO read strobe.
- rx_data  out  8  stream byte (header or payload).
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  sink accepts the byte when rx_valid and rx_ready are both high.
- rx_sop  out  1  qualifies the header byte.
- rx_eop  out  1  qualifies the last forwarded byte: last payload byte, or the header when length=0.
- pkt_done  out  1  one-cycle pulse after the parity byte is read or the packet is aborted.
- parity_err  out  1  valid with pkt_done: computed parity differed from the received parity byte.
- trunc_err  out  1  valid with pkt_done: packet aborted by stall timeout.
- pkt_count  out  16  count of completed packets (good or bad); wraps at 0xFFFF to 0.
- err_count  out  8  count of packets with parity_err or trunc_err; saturates at 0xFF.

Behaviour:
- Reset (resetn=0 at a clock edge): FSM to IDLE, buffer emptied, in-flight flag cleared. All outputs 0: read_enb, rx_valid, rx_sop, rx_eop, pkt_done, parity_err, trunc_err, pkt_count, err_count, rx_data. Reset mid-packet discards all state; no pkt_done is generated.
- FSM states: IDLE, WAIT, HDR, BODY, PAR, DONE.
- IDLE: when vld_out=1, go to WAIT and load the delay counter with START_DELAY. If START_DELAY=0, go directly to HDR.
- WAIT: decrement the counter; at 0 go to HDR. If vld_out drops, return to IDLE.
- HDR: issue one read.
  - On capture, latch len=data_out[7:2], initialise the parity accumulator to data_out, push the byte to the buffer with sop=1.
  - Go to BODY with remaining=len, or to PAR if len=0; in the len=0 case eop=1 on the header.
- BODY: issue reads until remaining reads reach 0.
  - Each captured byte is XORed into the accumulator and pushed to the buffer.
  - The last byte is pushed with eop=1. Then go to PAR.
- PAR: issue one read. The captured byte is compared with the accumulator and is not forwarded. Go to DONE.
- DONE: one cycle.
  - pkt_done=1 with parity_err as computed, trunc_err=0.
  - pkt_count+1; err_count+1 if parity_err.
  - Return to IDLE; a new packet may start the next cycle.
- Read issue rule:
  - read_enb=1 only in HDR/BODY/PAR, with vld_out=1, the state's read quota not yet exhausted, and (buffer occupancy + in-flight − pop_this_cycle) < 2.
  - At most one read is in flight. Capture occurs the cycle after read_enb.
  - A read issued while vld_out=0 is illegal and must never occur.
- Output buffer:
  - 2-entry FIFO of {data, sop, eop}. rx_* outputs are driven from the head entry.
  - Simultaneous push and pop is allowed.
  - With rx_ready held high, sustained throughput is one byte per clock after the first read. Latency from read_enb to rx_valid is 2 cycles.
- Backpressure: rx_ready=0 stalls reads once the buffer is full. Reads resume the cycle after a pop.
  - The sink must not hold rx_ready low ≥30 cycles while the FIFO is asserting vld_out; otherwise the router soft-resets the FIFO.
- Stall timeout:
  - In HDR/BODY/PAR, vld_out=0 for STALL_LIMIT consecutive cycles (e.g. the FIFO was soft-reset) triggers an abort.
  - Go to DONE with trunc_err=1 and parity_err=0; pkt_count and err_count both increment.
  - If the buffer holds bytes without eop, they are still delivered; the sink must use trunc_err to discard the packet.
- The parity accumulator and length are 8-bit and 6-bit respectively; no arithmetic overflow is possible.

Test Plan:
- Header 0x0D (len=3, addr 1), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33=0x0D, rx_ready=1 → rx stream 0D(sop),11,22,33(eop) on consecutive cycles; pkt_done with parity_err=0; pkt_count=1.
- Same packet with parity byte 0x00 → stream unchanged; pkt_done with parity_err=1; err_count=1.
- Header 0x02 (len=0), parity 0x02 → single byte 0x02 with sop=eop=1; pkt_done with no error; pkt_count increments.
- len=10 packet, rx_ready toggling 1,0,0,1 → no bytes lost or duplicated; read_enb low whenever the buffer is full; occupancy never exceeds 2.
- Header plus 2 of 5 payload bytes, then vld_out held low for 16 cycles → pkt_done with trunc_err=1; FSM back in IDLE; next packet parsed correctly.
- START_DELAY=5, vld_out rises at cycle 0 → first read_enb at cycle 6. resetn pulsed low mid-BODY → all outputs 0 the next cycle and no pkt_done.
